// File: rtl/acc_requant.sv
// Requantizes signed accumulator results to signed OUT_WIDTH through a 3-stage
// pipeline: bias add, scale multiply, round/shift/offset/saturate. The
// REQUANT_RELU_EN macro adds a per-beat ReLU lower bound (cfg_relu).
module acc_requant #(
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int MULT_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACC_WIDTH-1:0]   in_acc,
    input  logic [ACC_WIDTH-1:0]   cfg_bias,
    input  logic [MULT_WIDTH-1:0]  cfg_mult,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [OUT_WIDTH-1:0]   cfg_zero_point,
`ifdef REQUANT_RELU_EN
    input  logic                   cfg_relu,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic [CNT_WIDTH-1:0]   sat_count,
    input  logic                   sat_clr
);

    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam int PROD_W = ACC_WIDTH + MULT_WIDTH + 2;
    localparam int RND_W  = PROD_W + 1;
    localparam int V_W    = RND_W + 1;

    localparam logic signed [V_W-1:0] MAX_V = {{(V_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [V_W-1:0] MIN_V = {{(V_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Handshake: a beat moves on valid && ready. A stall (out_valid && !out_ready)
    // freezes every stage at once; otherwise all stages, bubbles included, advance.
    logic stall;
    logic adv;
    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = !stall;

    logic                   s1_valid_q;
    logic [SUM_W-1:0]       s1_sum_q;
    logic [MULT_WIDTH-1:0]  s1_mult_q;
    logic [SHIFT_WIDTH-1:0] s1_shift_q;
    logic [OUT_WIDTH-1:0]   s1_zp_q;
    logic                   s2_valid_q;
    logic [PROD_W-1:0]      s2_prod_q;
    logic [SHIFT_WIDTH-1:0] s2_shift_q;
    logic [OUT_WIDTH-1:0]   s2_zp_q;
    logic                   out_valid_q;
    logic [OUT_WIDTH-1:0]   out_data_q;
    logic                   out_sat_q;
    logic [CNT_WIDTH-1:0]   sat_cnt_q;

    logic [SUM_W-1:0]  sum_d;
    logic [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0] sum_ext;
    logic [PROD_W-1:0] mult_ext;

    assign sum_d    = {in_acc[ACC_WIDTH-1], in_acc} + {cfg_bias[ACC_WIDTH-1], cfg_bias};
    assign sum_ext  = {{(PROD_W-SUM_W){s1_sum_q[SUM_W-1]}}, s1_sum_q};
    assign mult_ext = {{(PROD_W-MULT_WIDTH){1'b0}}, s1_mult_q};
    // Truncated product of sign-extended operands equals the signed product.
    assign prod_d   = sum_ext * mult_ext;

    logic signed [RND_W-1:0] prod_sx;
    logic signed [RND_W-1:0] rnd;
    logic signed [RND_W-1:0] r;
    logic signed [V_W-1:0]   zp_ext;
    logic signed [V_W-1:0]   v;
    logic signed [V_W-1:0]   lo;
    logic [OUT_WIDTH-1:0]    data_d;
    logic                    sat_d;

`ifdef REQUANT_RELU_EN
    logic s1_relu_q;
    logic s2_relu_q;
`endif

    always_comb begin
        prod_sx = {s2_prod_q[PROD_W-1], s2_prod_q};
        // Half-LSB rounding constant; zero when the shift is zero.
        rnd     = ({{(RND_W-1){1'b0}}, 1'b1} << s2_shift_q) >> 1;
        r       = (prod_sx + rnd) >>> s2_shift_q;
        zp_ext  = {{(V_W-OUT_WIDTH){s2_zp_q[OUT_WIDTH-1]}}, s2_zp_q};
        v       = {r[RND_W-1], r} + zp_ext;
        lo      = MIN_V;
`ifdef REQUANT_RELU_EN
        if (s2_relu_q && (zp_ext > MIN_V)) lo = zp_ext;
`endif
        data_d = v[OUT_WIDTH-1:0];
        sat_d  = 1'b0;
        if (v > MAX_V) begin
            data_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat_d  = 1'b1;
        end else if (v < lo) begin
            data_d = lo[OUT_WIDTH-1:0];
            sat_d  = (lo == MIN_V);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_mult_q   <= '0;
            s1_shift_q  <= '0;
            s1_zp_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_shift_q  <= '0;
            s2_zp_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
`ifdef REQUANT_RELU_EN
            s1_relu_q   <= 1'b0;
            s2_relu_q   <= 1'b0;
`endif
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            s1_sum_q    <= sum_d;
            s1_mult_q   <= cfg_mult;
            s1_shift_q  <= cfg_shift;
            s1_zp_q     <= cfg_zero_point;
            s2_valid_q  <= s1_valid_q;
            s2_prod_q   <= prod_d;
            s2_shift_q  <= s1_shift_q;
            s2_zp_q     <= s1_zp_q;
            out_valid_q <= s2_valid_q;
            out_data_q  <= data_d;
            out_sat_q   <= sat_d;
`ifdef REQUANT_RELU_EN
            s1_relu_q   <= cfg_relu;
            s2_relu_q   <= s1_relu_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (sat_clr) begin
            sat_cnt_q <= '0;
        end else if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != {CNT_WIDTH{1'b1}})) begin
            sat_cnt_q <= sat_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_cnt_q;

endmodule
